// File: rtl/axi3_slave_ram.sv
// AXI3 responder backed by an on-chip RAM: one write burst and one read burst
// in flight at a time, each with its own FSM, errors reported via bresp/rresp.
module axi3_slave_ram #(
    parameter int DataBits = 64,
    parameter int AddrBits = 32,
    parameter int MemWords = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  slv_awvalid,
    output logic                  slv_awready,
    input  logic [3:0]            slv_awid,
    input  logic [AddrBits-1:0]   slv_awaddr,
    input  logic [3:0]            slv_awlen,
    input  logic [2:0]            slv_awsize,
    input  logic [1:0]            slv_awburst,
    input  logic [1:0]            slv_awlock,
    input  logic                  slv_wvalid,
    output logic                  slv_wready,
    input  logic [3:0]            slv_wid,
    input  logic [DataBits-1:0]   slv_wdata,
    input  logic [DataBits/8-1:0] slv_wstrb,
    input  logic                  slv_wlast,
    output logic                  slv_bvalid,
    input  logic                  slv_bready,
    output logic [3:0]            slv_bid,
    output logic [1:0]            slv_bresp,
    input  logic                  slv_arvalid,
    output logic                  slv_arready,
    input  logic [3:0]            slv_arid,
    input  logic [AddrBits-1:0]   slv_araddr,
    input  logic [3:0]            slv_arlen,
    input  logic [2:0]            slv_arsize,
    input  logic [1:0]            slv_arburst,
    input  logic [1:0]            slv_arlock,
    output logic                  slv_rvalid,
    input  logic                  slv_rready,
    output logic [3:0]            slv_rid,
    output logic [DataBits-1:0]   slv_rdata,
    output logic [1:0]            slv_rresp,
    output logic                  slv_rlast
);
    localparam int Bytes = DataBits / 8;
    localparam int Off   = $clog2(Bytes);
    localparam int IdxW  = $clog2(MemWords);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    function automatic logic in_range(input logic [AddrBits-1:0] a);
        return (a >> Off) < AddrBits'(MemWords);
    endfunction

    function automatic logic [AddrBits-1:0] next_addr(input logic [AddrBits-1:0] a,
                                                       input logic [1:0] burst);
        return (burst == 2'b01) ? a + AddrBits'(Bytes) : a;
    endfunction

    // WRAP, reserved burst types and any size other than the full bus width are refused.
    function automatic logic cfg_bad(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size != 3'(Off));
    endfunction

    function automatic logic [1:0] resp_code(input logic dec, input logic slv);
        return dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endfunction

    logic unused_lock;
    assign unused_lock = ^{slv_awlock, slv_arlock};

    logic [DataBits-1:0] mem [MemWords];

    // Write channel
    wstate_t             w_state, w_next;
    logic [3:0]          w_id, w_len, w_beat;
    logic [AddrBits-1:0] w_addr;
    logic [1:0]          w_burst;
    logic                w_cfg_err, w_dec, w_slv;
    logic                w_take, w_en;

    assign w_take  = (w_state == W_DATA) && slv_wvalid;
    assign w_en    = w_take && in_range(w_addr) && !w_cfg_err;
    assign slv_bid = w_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) w_state <= W_IDLE;
        else      w_state <= w_next;
    end

    always_comb begin
        w_next      = w_state;
        slv_awready = 1'b0;
        slv_wready  = 1'b0;
        slv_bvalid  = 1'b0;
        slv_bresp   = 2'b00;
        case (w_state)
            W_IDLE: begin
                slv_awready = 1'b1;
                if (slv_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                slv_wready = 1'b1;
                if (slv_wvalid && (w_beat == w_len)) w_next = W_RESP;
            end
            W_RESP: begin
                slv_bvalid = 1'b1;
                slv_bresp  = resp_code(w_dec, w_slv);
                if (slv_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_id      <= '0;
            w_len     <= '0;
            w_beat    <= '0;
            w_addr    <= '0;
            w_burst   <= '0;
            w_cfg_err <= 1'b0;
            w_dec     <= 1'b0;
            w_slv     <= 1'b0;
        end else begin
            if (w_state == W_IDLE && slv_awvalid) begin
                w_id      <= slv_awid;
                w_len     <= slv_awlen;
                w_beat    <= '0;
                w_addr    <= slv_awaddr;
                w_burst   <= slv_awburst;
                w_cfg_err <= cfg_bad(slv_awburst, slv_awsize);
                w_dec     <= 1'b0;
                w_slv     <= cfg_bad(slv_awburst, slv_awsize);
            end
            if (w_take) begin
                w_beat <= w_beat + 4'd1;
                w_addr <= next_addr(w_addr, w_burst);
                if (!in_range(w_addr)) w_dec <= 1'b1;
                if ((slv_wid != w_id) || (slv_wlast != (w_beat == w_len))) w_slv <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int b = 0; b < Bytes; b++) begin
                if (slv_wstrb[b]) mem[w_addr[Off +: IdxW]][b*8 +: 8] <= slv_wdata[b*8 +: 8];
            end
        end
    end

    // Read channel: the next word is fetched on the same edge that retires the current beat
    rstate_t             r_state, r_next;
    logic [3:0]          r_id, r_len, r_beat;
    logic [AddrBits-1:0] r_addr, f_addr;
    logic [1:0]          r_burst;
    logic                r_cfg_err, r_take, r_last, f_en;

    assign r_last  = (r_beat == r_len);
    assign r_take  = (r_state == R_DATA) && slv_rready;
    assign f_addr  = (r_state == R_FETCH) ? r_addr : next_addr(r_addr, r_burst);
    assign f_en    = (r_state == R_FETCH) || (r_take && !r_last);
    assign slv_rid = r_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= r_next;
    end

    always_comb begin
        r_next      = r_state;
        slv_arready = 1'b0;
        slv_rvalid  = 1'b0;
        slv_rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                slv_arready = 1'b1;
                if (slv_arvalid) r_next = R_FETCH;
            end
            R_FETCH: r_next = R_DATA;
            R_DATA: begin
                slv_rvalid = 1'b1;
                slv_rlast  = r_last;
                if (slv_rready && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id      <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_addr    <= '0;
            r_burst   <= '0;
            r_cfg_err <= 1'b0;
            slv_rdata <= '0;
            slv_rresp <= 2'b00;
        end else begin
            if (r_state == R_IDLE && slv_arvalid) begin
                r_id      <= slv_arid;
                r_len     <= slv_arlen;
                r_beat    <= '0;
                r_addr    <= slv_araddr;
                r_burst   <= slv_arburst;
                r_cfg_err <= cfg_bad(slv_arburst, slv_arsize);
            end
            if (f_en) begin
                slv_rdata <= (in_range(f_addr) && !r_cfg_err) ? mem[f_addr[Off +: IdxW]] : '0;
                slv_rresp <= resp_code(!in_range(f_addr), r_cfg_err);
            end
            if (r_take && !r_last) begin
                r_addr <= f_addr;
                r_beat <= r_beat + 4'd1;
            end
        end
    end
endmodule
